// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable modulo-N down counter with one-shot/auto-reload modes
// Terminal-count pulse on reaching 0; busy/done decoded from the state register.
module sync_down_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
  logic             mode;
  logic             mode_next;
  logic             tc_next;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      tc     <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      mode   <= mode_next;
      tc     <= tc_next;
    end
  end

  // tc defaults low so a pulse can never be stretched by hold or by DONE.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    mode_next   = mode;
    tc_next     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_next = IDLE;
          count_next = '0;
        end else if (load) begin
          reload_next = load_val;
          mode_next   = auto_reload;
          if (load_val != '0) begin
            count_next = load_val;
            state_next = RUN;
          end else begin
            count_next = '0;
            tc_next    = 1'b1;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
          count_next = '0;
        end else if (hold) begin
          count_next = count;
        end else if (count > ONE) begin
          count_next = count - ONE;
        end else if (count == ONE) begin
          count_next = '0;
          tc_next    = 1'b1;
          if (!mode) state_next = DONE;
        end else if (mode) begin
          count_next = reload;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
